bin_loader: RTL and testbench

- Serves the bin-swap requests of the solver control FSM.
- On a load request, copies one bin's clauses and its per-bin variable states from global memories into the local clause and variable arrays used by BCP, decision and analysis.
- On an update request, writes the local variable states of the current bin back to global variable memory.
- Sits between the control FSM and the global clause/variable RAMs. All handshakes are single-cycle pulses.

---
 rtl/solver_pkg.sv | 48 ++++
 rtl/bin_loader_if.sv | 56 +++++
 rtl/bin_loader_rd_pipe.sv | 25 ++
 rtl/bin_loader.sv | 169 ++++++++++++++++
 tb/tb_bin_loader.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/solver_pkg.sv
// Shared widths, bin geometry, variable-state field offsets and the
// bin loader state encoding.
package solver_pkg;

   localparam int ADDR_WIDTH        = 31;
   localparam int WIDTH_BIN_I       = 16;
   localparam int WIDTH_TOTAL_BIN   = 16;
   localparam int NUM_CLAUSES_A_BIN = 8;
   localparam int NUM_VARS_A_BIN    = 18;
   localparam int WIDTH_CLAUSE      = 2 * NUM_VARS_A_BIN;
   localparam int WIDTH_VAR_STATE   = 19;

   localparam int C = NUM_CLAUSES_A_BIN;
   localparam int V = NUM_VARS_A_BIN;

   localparam int LC_IDX_W = $clog2(C);
   localparam int LV_IDX_W = $clog2(V);
   localparam int CNT_W    = (LV_IDX_W > LC_IDX_W) ? LV_IDX_W : LC_IDX_W;

   // variable state layout: {level[15:0], implied, value[1:0]}
   localparam int VS_VALUE_LSB   = 0;
   localparam int VS_VALUE_W     = 2;
   localparam int VS_IMPLIED_BIT = 2;
   localparam int VS_LEVEL_LSB   = 3;
   localparam int VS_LEVEL_W     = 16;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LD_CLAUSE = 3'd1,
      LD_VAR    = 3'd2,
      LD_FLUSH  = 3'd3,
      LD_DONE   = 3'd4,
      UP_VAR    = 3'd5,
      UP_DONE   = 3'd6
   } bl_state_e;

   // bin * per_bin + idx, wrapping at the global address width
   function automatic logic [ADDR_WIDTH-1:0] bin_addr(
      input logic [WIDTH_BIN_I-1:0] bin,
      input logic [ADDR_WIDTH-1:0]  per_bin,
      input logic [CNT_W-1:0]       idx
   );
      logic [ADDR_WIDTH-1:0] a;
      a = ADDR_WIDTH'(bin) * per_bin + ADDR_WIDTH'(idx);
      return a;
   endfunction

endpackage

// File: rtl/bin_loader_if.sv
// Control handshakes plus global RAM and local array ports of the bin loader.
// master = loader side, slave = control FSM / memories side.
interface bin_loader_if;
   import solver_pkg::*;

   logic                       start_load_i;
   logic [WIDTH_BIN_I-1:0]     bin_num_i;
   logic [WIDTH_TOTAL_BIN-1:0] total_bin_num_i;
   logic                       done_load_o;
   logic                       start_update_i;
   logic                       done_update_o;
   logic                       busy_o;
   logic                       err_o;
   logic [WIDTH_BIN_I-1:0]     cur_bin_num_o;

   logic                       cmem_rd_en_o;
   logic [ADDR_WIDTH-1:0]      cmem_addr_o;
   logic [WIDTH_CLAUSE-1:0]    cmem_rdata_i;

   logic                       vmem_rd_en_o;
   logic                       vmem_wr_en_o;
   logic [ADDR_WIDTH-1:0]      vmem_addr_o;
   logic [WIDTH_VAR_STATE-1:0] vmem_wdata_o;
   logic [WIDTH_VAR_STATE-1:0] vmem_rdata_i;

   logic                       lc_wr_en_o;
   logic [LC_IDX_W-1:0]        lc_index_o;
   logic [WIDTH_CLAUSE-1:0]    lc_data_o;

   logic                       lv_wr_en_o;
   logic [LV_IDX_W-1:0]        lv_index_o;
   logic [WIDTH_VAR_STATE-1:0] lv_data_o;
   logic [LV_IDX_W-1:0]        lv_rd_index_o;
   logic [WIDTH_VAR_STATE-1:0] lv_rd_data_i;

   modport master (
      input  start_load_i, bin_num_i, total_bin_num_i, start_update_i,
             cmem_rdata_i, vmem_rdata_i, lv_rd_data_i,
      output done_load_o, done_update_o, busy_o, err_o, cur_bin_num_o,
             cmem_rd_en_o, cmem_addr_o,
             vmem_rd_en_o, vmem_wr_en_o, vmem_addr_o, vmem_wdata_o,
             lc_wr_en_o, lc_index_o, lc_data_o,
             lv_wr_en_o, lv_index_o, lv_data_o, lv_rd_index_o
   );

   modport slave (
      output start_load_i, bin_num_i, total_bin_num_i, start_update_i,
             cmem_rdata_i, vmem_rdata_i, lv_rd_data_i,
      input  done_load_o, done_update_o, busy_o, err_o, cur_bin_num_o,
             cmem_rd_en_o, cmem_addr_o,
             vmem_rd_en_o, vmem_wr_en_o, vmem_addr_o, vmem_wdata_o,
             lc_wr_en_o, lc_index_o, lc_data_o,
             lv_wr_en_o, lv_index_o, lv_data_o, lv_rd_index_o
   );

endinterface

// File: rtl/bin_loader_rd_pipe.sv
// One-stage valid/index delay so the local write index lines up with RAM
// read data that returns one cycle after the read enable.
module bin_rd_pipe #(
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue_i,
   input  logic [IDX_W-1:0] index_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] index_o
);

   // delay the read issue and its index by one cycle
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_o <= 1'b0;
         index_o <= '0;
      end else begin
         valid_o <= issue_i;
         index_o <= issue_i ? index_i : '0;
      end
   end

endmodule

// File: rtl/bin_loader.sv
// Bin swap engine: loads a bin's clauses and variable states into the local
// arrays, and writes the local variable states back to global memory.
//
// state     | meaning
// ----------+----------------------------------------------------
// IDLE      | waiting for a load or update request
// LD_CLAUSE | issuing clause RAM reads, k = 0..C-1
// LD_VAR    | issuing variable RAM reads, i = 0..V-1
// LD_FLUSH  | last variable read lands in the local array
// LD_DONE   | done_load_o pulse (also the bad-bin error path)
// UP_VAR    | writing local variable i back to global memory
// UP_DONE   | done_update_o pulse (also the no-bin-loaded error path)
module bin_loader
   import solver_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   bin_loader_if.master bus
);

   bl_state_e              state, state_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic [WIDTH_BIN_I-1:0] cur_bin, cur_bin_nxt;
   logic                   err, err_nxt;
   logic                   loaded, loaded_nxt;

   logic                   lc_valid;
   logic [LC_IDX_W-1:0]    lc_idx;
   logic                   lv_valid;
   logic [LV_IDX_W-1:0]    lv_idx;

   bin_rd_pipe #(.IDX_W(LC_IDX_W)) u_cpipe (
      .clk     (clk),
      .rst     (rst),
      .issue_i (bus.cmem_rd_en_o),
      .index_i (cnt[LC_IDX_W-1:0]),
      .valid_o (lc_valid),
      .index_o (lc_idx)
   );

   bin_rd_pipe #(.IDX_W(LV_IDX_W)) u_vpipe (
      .clk     (clk),
      .rst     (rst),
      .issue_i (bus.vmem_rd_en_o),
      .index_i (cnt[LV_IDX_W-1:0]),
      .valid_o (lv_valid),
      .index_o (lv_idx)
   );

   // state, index counter, current bin and sticky flags
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         cur_bin <= '0;
         err     <= 1'b0;
         loaded  <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         cur_bin <= cur_bin_nxt;
         err     <= err_nxt;
         loaded  <= loaded_nxt;
      end
   end

   // next-state logic and memory-side outputs
   always_comb begin
      state_nxt         = state;
      cnt_nxt           = cnt;
      cur_bin_nxt       = cur_bin;
      err_nxt           = err;
      loaded_nxt        = loaded;
      bus.done_load_o   = 1'b0;
      bus.done_update_o = 1'b0;
      bus.cmem_rd_en_o  = 1'b0;
      bus.cmem_addr_o   = '0;
      bus.vmem_rd_en_o  = 1'b0;
      bus.vmem_wr_en_o  = 1'b0;
      bus.vmem_addr_o   = '0;
      bus.vmem_wdata_o  = '0;
      bus.lv_rd_index_o = '0;

      case (state)
         IDLE: begin
            if (bus.start_load_i) begin
               cnt_nxt = '0;
               if (bus.start_update_i) err_nxt = 1'b1;
               if (bus.bin_num_i >= bus.total_bin_num_i) begin
                  err_nxt   = 1'b1;
                  state_nxt = LD_DONE;
               end else begin
                  cur_bin_nxt = bus.bin_num_i;
                  loaded_nxt  = 1'b1;
                  state_nxt   = LD_CLAUSE;
               end
            end else if (bus.start_update_i) begin
               cnt_nxt = '0;
               if (!loaded) begin
                  err_nxt   = 1'b1;
                  state_nxt = UP_DONE;
               end else begin
                  state_nxt = UP_VAR;
               end
            end
         end
         LD_CLAUSE: begin
            bus.cmem_rd_en_o = 1'b1;
            bus.cmem_addr_o  = bin_addr(cur_bin, ADDR_WIDTH'(C), cnt);
            if (cnt == CNT_W'(C - 1)) begin
               cnt_nxt   = '0;
               state_nxt = LD_VAR;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         LD_VAR: begin
            bus.vmem_rd_en_o = 1'b1;
            bus.vmem_addr_o  = bin_addr(cur_bin, ADDR_WIDTH'(V), cnt);
            if (cnt == CNT_W'(V - 1)) begin
               cnt_nxt   = '0;
               state_nxt = LD_FLUSH;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         LD_FLUSH: state_nxt = LD_DONE;
         LD_DONE: begin
            bus.done_load_o = 1'b1;
            state_nxt       = IDLE;
         end
         UP_VAR: begin
            bus.lv_rd_index_o = cnt[LV_IDX_W-1:0];
            bus.vmem_wr_en_o  = 1'b1;
            bus.vmem_addr_o   = bin_addr(cur_bin, ADDR_WIDTH'(V), cnt);
            bus.vmem_wdata_o  = bus.lv_rd_data_i;
            if (cnt == CNT_W'(V - 1)) begin
               cnt_nxt   = '0;
               state_nxt = UP_DONE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         UP_DONE: begin
            bus.done_update_o = 1'b1;
            state_nxt         = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // requests arriving mid-operation are dropped but flagged
      if (state != IDLE && (bus.start_load_i || bus.start_update_i))
         err_nxt = 1'b1;
   end

   // status and local-array write side
   always_comb begin
      bus.busy_o        = (state != IDLE);
      bus.err_o         = err;
      bus.cur_bin_num_o = cur_bin;
      bus.lc_wr_en_o    = lc_valid;
      bus.lc_index_o    = lc_idx;
      bus.lc_data_o     = lc_valid ? bus.cmem_rdata_i : '0;
      bus.lv_wr_en_o    = lv_valid;
      bus.lv_index_o    = lv_idx;
      bus.lv_data_o     = lv_valid ? bus.vmem_rdata_i : '0;
   end

endmodule

// File: tb/tb_bin_loader.sv
// Scoreboard bench for bin_loader: stimulus pushes expected local/RAM writes
// and done pulses (with their cycle offsets); a negedge monitor pops them.
module tb_bin_loader;
   import solver_pkg::*;

   localparam int K_LC = 0;
   localparam int K_LV = 1;
   localparam int K_VW = 2;
   localparam int K_DL = 3;
   localparam int K_DU = 4;

   typedef struct {
      int kind;
      int a;
      int d;
      int cyc;
   } ev_t;

   logic clk;
   logic rst;
   bin_loader_if bus();

   bin_loader dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   ev_t  q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   start_cyc = 0;
   int   en_cnt = 0;
   int   vw_cnt = 0;
   int   du_cnt = 0;
   int   multi_en = 0;
   logic [WIDTH_VAR_STATE-1:0] lv_arr [0:31];

   always @(posedge clk) cyc <= cyc + 1;

   // global RAM models with one-cycle read latency, plus local variable array
   always @(posedge clk) begin
      if (bus.cmem_rd_en_o) bus.cmem_rdata_i <= WIDTH_CLAUSE'(bus.cmem_addr_o + 100);
      if (bus.vmem_rd_en_o) bus.vmem_rdata_i <= WIDTH_VAR_STATE'(bus.vmem_addr_o + 500);
      if (bus.lv_wr_en_o)   lv_arr[bus.lv_index_o] <= bus.lv_data_o;
   end
   assign bus.lv_rd_data_i = lv_arr[bus.lv_rd_index_o];

   function automatic string kname(input int k);
      case (k)
         K_LC:    return "lc_write";
         K_LV:    return "lv_write";
         K_VW:    return "vmem_write";
         K_DL:    return "done_load";
         default: return "done_update";
      endcase
   endfunction

   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic push(input int kind, input int a, input int d, input int c);
      ev_t e;
      e.kind = kind; e.a = a; e.d = d; e.cyc = c;
      q.push_back(e);
   endtask

   task automatic check_ev(input int kind, input int a, input int d);
      ev_t e;
      int  rel;
      rel = cyc - start_cyc;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_%s got a=%0d d=%0d cyc=%0d expected no event",
                  kname(kind), a, d, rel);
      end else begin
         e = q.pop_front();
         if (e.kind != kind || e.a != a || e.d != d || e.cyc != rel) begin
            errors++;
            $display("FAIL %s got %s a=%0d d=%0d cyc=%0d expected %s a=%0d d=%0d cyc=%0d",
                     kname(e.kind), kname(kind), a, d, rel, kname(e.kind), e.a, e.d, e.cyc);
         end
      end
   endtask

   // monitor
   always @(negedge clk) begin
      if (bus.cmem_rd_en_o || bus.vmem_rd_en_o || bus.vmem_wr_en_o) en_cnt++;
      if (int'(bus.cmem_rd_en_o) + int'(bus.vmem_rd_en_o) + int'(bus.vmem_wr_en_o) > 1)
         multi_en++;
      if (bus.vmem_wr_en_o)  vw_cnt++;
      if (bus.done_update_o) du_cnt++;
      if (bus.lc_wr_en_o)    check_ev(K_LC, int'(bus.lc_index_o), int'(bus.lc_data_o));
      if (bus.lv_wr_en_o)    check_ev(K_LV, int'(bus.lv_index_o), int'(bus.lv_data_o));
      if (bus.vmem_wr_en_o)  check_ev(K_VW, int'(bus.vmem_addr_o), int'(bus.vmem_wdata_o));
      if (bus.done_load_o)   check_ev(K_DL, 0, 0);
      if (bus.done_update_o) check_ev(K_DU, 0, 0);
   end

   function automatic logic any_out();
      return |{bus.done_load_o, bus.done_update_o, bus.busy_o, bus.err_o,
               bus.cur_bin_num_o, bus.cmem_rd_en_o, bus.cmem_addr_o,
               bus.vmem_rd_en_o, bus.vmem_wr_en_o, bus.vmem_addr_o, bus.vmem_wdata_o,
               bus.lc_wr_en_o, bus.lc_index_o, bus.lc_data_o,
               bus.lv_wr_en_o, bus.lv_index_o, bus.lv_data_o, bus.lv_rd_index_o};
   endfunction

   task automatic push_load(input int b);
      for (int k = 0; k < C; k++) push(K_LC, k, b * C + k + 100, k + 2);
      for (int i = 0; i < V; i++) push(K_LV, i, b * V + i + 500, C + 2 + i);
      push(K_DL, 0, 0, C + V + 2);
   endtask

   task automatic start_op(input bit ld, input bit up, input int b, input int total);
      @(negedge clk);
      bus.start_load_i    = ld;
      bus.start_update_i  = up;
      bus.bin_num_i       = WIDTH_BIN_I'(b);
      bus.total_bin_num_i = WIDTH_TOTAL_BIN'(total);
      start_cyc = cyc;
      @(negedge clk);
      bus.start_load_i   = 1'b0;
      bus.start_update_i = 1'b0;
   endtask

   task automatic wait_done(input string name, input bit upd, input int limit);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < limit; n++) begin
         if (upd ? bus.done_update_o : bus.done_load_o) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check({name, "_timeout"}, seen, 1);
      @(negedge clk);
      check({name, "_busy_after"}, bus.busy_o, 0);
      check({name, "_queue_left"}, q.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      rst                 = 1'b0;
      bus.start_load_i    = 1'b0;
      bus.start_update_i  = 1'b0;
      bus.bin_num_i       = '0;
      bus.total_bin_num_i = '0;
      bus.cmem_rdata_i    = '0;
      bus.vmem_rdata_i    = '0;
      for (int i = 0; i < 32; i++) lv_arr[i] = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs_zero", any_out(), 0);
      rst = 1'b1;

      // normal load of bin 2
      push_load(2);
      start_op(1'b1, 1'b0, 2, 4);
      wait_done("load_b2", 1'b0, 60);
      check("load_b2_cur_bin", bus.cur_bin_num_o, 2);
      check("load_b2_err", bus.err_o, 0);

      // write-back of modified local states
      for (int i = 0; i < V; i++) lv_arr[i] <= WIDTH_VAR_STATE'(i + 7);
      for (int i = 0; i < V; i++) push(K_VW, 2 * V + i, i + 7, i + 1);
      push(K_DU, 0, 0, V + 1);
      start_op(1'b0, 1'b1, 0, 4);
      wait_done("update_b2", 1'b1, 60);
      check("update_b2_err", bus.err_o, 0);

      // out-of-range bin
      en_cnt = 0;
      push(K_DL, 0, 0, 1);
      start_op(1'b1, 1'b0, 4, 4);
      wait_done("load_bad_bin", 1'b0, 10);
      check("bad_bin_err", bus.err_o, 1);
      check("bad_bin_cur_bin", bus.cur_bin_num_o, 2);
      check("bad_bin_ram_enables", en_cnt, 0);

      // load and update together: load wins, update dropped
      do_reset();
      check("reset_err_clear", bus.err_o, 0);
      check("reset_cur_bin_clear", bus.cur_bin_num_o, 0);
      du_cnt = 0;
      push_load(1);
      start_op(1'b1, 1'b1, 1, 4);
      wait_done("load_both", 1'b0, 60);
      check("both_err", bus.err_o, 1);
      check("both_cur_bin", bus.cur_bin_num_o, 1);
      check("both_no_done_update", du_cnt, 0);

      // reset in cycle 10 of a load, then a clean load
      for (int k = 0; k < C; k++) push(K_LC, k, 3 * C + k + 100, k + 2);
      push(K_LV, 0, 3 * V + 500, C + 2);
      start_op(1'b1, 1'b0, 3, 4);
      for (int n = 0; n < 40; n++) begin
         if (cyc - start_cyc == 10) break;
         @(negedge clk);
      end
      check("abort_reached_cycle10", cyc - start_cyc, 10);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("abort_outputs_zero", any_out(), 0);
      @(negedge clk);
      rst = 1'b1;
      check("abort_queue_left", q.size(), 0);
      push_load(3);
      start_op(1'b1, 1'b0, 3, 4);
      wait_done("load_after_abort", 1'b0, 60);
      check("after_abort_cur_bin", bus.cur_bin_num_o, 3);
      check("after_abort_err", bus.err_o, 0);

      // update without any prior load
      do_reset();
      vw_cnt = 0;
      push(K_DU, 0, 0, 1);
      start_op(1'b0, 1'b1, 0, 4);
      wait_done("update_no_load", 1'b1, 10);
      check("no_load_err", bus.err_o, 1);
      check("no_load_vmem_writes", vw_cnt, 0);

      check("one_mem_enable_per_cycle", multi_en, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
